// File: rtl/spram_arbiter.sv
// Round-robin arbiter and init sequencer for one single-port SRAM.
// Sweeps the array with INIT_VALUE after reset or init_start, then shares it between requesters.
module spram_arbiter #(
   parameter int unsigned          NUM_REQ    = 2,
   parameter int unsigned          MEM_WIDTH  = 32,
   parameter int unsigned          MEM_DEPTH  = 4096,
   parameter logic [MEM_WIDTH-1:0] INIT_VALUE = '0,
   localparam int unsigned         AW         = $clog2(MEM_DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ-1:0]           req_we,
   input  logic [NUM_REQ*AW-1:0]        req_addr,
   input  logic [NUM_REQ*MEM_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]           rsp_valid,
   output logic [MEM_WIDTH-1:0]         rsp_rdata,
   input  logic                         init_start,
   output logic                         init_busy,
   output logic                         mem_cen,
   output logic                         mem_wen,
   output logic [AW-1:0]                mem_addr,
   output logic [MEM_WIDTH-1:0]         mem_d,
   input  logic [MEM_WIDTH-1:0]         mem_q
);

   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {INIT, SERVE} state_t;

   state_t              state;
   logic [AW-1:0]       cnt;
   logic [IW-1:0]       rr_ptr;
   logic [IW-1:0]       gnt_idx;
   logic                gnt_any;
   logic [NUM_REQ-1:0]  grant;
   int unsigned         idx;
   logic                s1_vld, s2_vld;
   logic [IW-1:0]       s1_id, s2_id;

   // First valid requester at or after rr_ptr, wrapping; never while sweeping or restarting.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      if (state == SERVE && !init_start) begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_any && req_valid[idx]) begin
               gnt_any    = 1'b1;
               gnt_idx    = IW'(idx);
               grant[idx] = 1'b1;
            end
         end
      end
   end

   assign req_ready = grant;
   assign init_busy = (state == INIT);
   assign rsp_rdata = mem_q;

   always_comb begin
      rsp_valid = '0;
      if (s2_vld) rsp_valid[s2_id] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= INIT;
         cnt      <= '0;
         rr_ptr   <= '0;
         mem_cen  <= 1'b1;
         mem_wen  <= 1'b1;
         mem_addr <= '0;
         mem_d    <= '0;
         s1_vld   <= 1'b0;
         s1_id    <= '0;
         s2_vld   <= 1'b0;
         s2_id    <= '0;
      end else begin
         // Read tracking keeps running across a restart so in-flight reads still respond.
         s2_vld <= s1_vld;
         s2_id  <= s1_id;
         s1_vld <= 1'b0;
         s1_id  <= gnt_idx;
         case (state)
            INIT: begin
               mem_cen  <= 1'b0;
               mem_wen  <= 1'b0;
               mem_addr <= cnt;
               mem_d    <= INIT_VALUE;
               if (cnt == AW'(MEM_DEPTH - 1)) begin
                  state <= SERVE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SERVE: begin
               if (gnt_any) begin
                  mem_cen  <= 1'b0;
                  mem_wen  <= ~req_we[gnt_idx];
                  mem_addr <= req_addr[gnt_idx*AW +: AW];
                  mem_d    <= req_wdata[gnt_idx*MEM_WIDTH +: MEM_WIDTH];
                  rr_ptr   <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                  s1_vld   <= ~req_we[gnt_idx];
               end else begin
                  mem_cen <= 1'b1;
                  mem_wen <= 1'b1;
               end
               if (init_start) state <= INIT;
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter with a behavioural SRAM and a read-response scoreboard.
module tb_spram_arbiter;

   localparam int unsigned N  = 2;
   localparam int unsigned W  = 32;
   localparam int unsigned D  = 16;
   localparam int unsigned AW = 4;
   localparam logic [W-1:0] IV = 32'hC0DE_0F0F;

   typedef struct {
      int unsigned  id;
      logic [W-1:0] data;
      int unsigned  due;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req_valid = '0;
   logic [N-1:0]     req_ready;
   logic [N-1:0]     req_we = '0;
   logic [N*AW-1:0]  req_addr = '0;
   logic [N*W-1:0]   req_wdata = '0;
   logic [N-1:0]     rsp_valid;
   logic [W-1:0]     rsp_rdata;
   logic             init_start = 1'b0;
   logic             init_busy;
   logic             mem_cen, mem_wen;
   logic [AW-1:0]    mem_addr;
   logic [W-1:0]     mem_d;
   logic [W-1:0]     mem_q;

   logic [W-1:0]     sram [D];
   logic [W-1:0]     exp_mem [D];
   exp_t             sbq [$];
   int unsigned      checks = 0;
   int unsigned      errors = 0;
   int unsigned      cyc = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!mem_cen) begin
         if (!mem_wen) sram[mem_addr] <= mem_d;
         else          mem_q <= sram[mem_addr];
      end
   end

   spram_arbiter #(
      .NUM_REQ(N), .MEM_WIDTH(W), .MEM_DEPTH(D), .INIT_VALUE(IV)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .init_start(init_start), .init_busy(init_busy),
      .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_d(mem_d), .mem_q(mem_q)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then compare the response port against the scoreboard head.
   task automatic step();
      exp_t        e;
      logic [N-1:0] oh;
      @(posedge clk);
      #1;
      cyc++;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
         e  = sbq.pop_front();
         oh = N'(1) << e.id;
         chk("rsp_valid", 64'(rsp_valid), 64'(oh));
         chk("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
      end else begin
         chk("rsp_idle", 64'(rsp_valid), 64'(0));
      end
   endtask

   task automatic drain(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step();
   endtask

   task automatic do_req(input int unsigned id, input logic we, input logic [AW-1:0] a,
                         input logic [W-1:0] dat);
      logic [N-1:0] oh;
      oh                   = N'(1) << id;
      req_valid            = oh;
      req_we[id]           = we;
      req_addr[id*AW +: AW] = a;
      req_wdata[id*W +: W] = dat;
      #1;
      chk("grant_single", 64'(req_ready), 64'(oh));
      if (!we) sbq.push_back('{id, exp_mem[a], cyc + 2});
      else     exp_mem[a] = dat;
      step();
      req_valid = '0;
      chk("acc_cen", 64'(mem_cen), 64'(0));
      chk("acc_wen", 64'(mem_wen), 64'(!we));
      chk("acc_addr", 64'(mem_addr), 64'(a));
      chk("acc_d", 64'(mem_d), 64'(dat));
   endtask

   // Full sweep: requests held off, 16 busy cycles writing addresses 0..15 in order.
   task automatic sweep();
      for (int unsigned k = 1; k <= D; k++) begin
         req_valid = (k < D) ? '1 : '0;
         req_we    = '1;
         #1;
         chk("init_no_grant", 64'(req_ready), 64'(0));
         chk("init_busy_pre", 64'(init_busy), 64'(1));
         step();
         chk("init_cen", 64'(mem_cen), 64'(0));
         chk("init_wen", 64'(mem_wen), 64'(0));
         chk("init_addr", 64'(mem_addr), 64'(k - 1));
         chk("init_d", 64'(mem_d), 64'(IV));
         chk("init_busy_post", 64'(init_busy), 64'(k < D));
      end
      req_valid = '0;
      req_we    = '0;
      for (int unsigned a = 0; a < D; a++) exp_mem[a] = IV;
   endtask

   initial begin
      logic [N-1:0] g;
      drain(2);
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_busy", 64'(init_busy), 64'(1));
      chk("rst_cen", 64'(mem_cen), 64'(1));
      chk("rst_wen", 64'(mem_wen), 64'(1));
      chk("rst_addr", 64'(mem_addr), 64'(0));
      chk("rst_d", 64'(mem_d), 64'(0));
      rst = 1'b0;
      sweep();

      do_req(1, 1'b1, 4'd5, 32'h0000_00A5);
      do_req(0, 1'b0, 4'd5, 32'h0);
      drain(3);

      do_req(0, 1'b1, 4'd1, 32'h0000_0011);
      do_req(1, 1'b1, 4'd2, 32'h0000_0022);
      req_valid = '1;
      req_we    = '0;
      req_addr  = {4'd2, 4'd1};
      for (int unsigned i = 0; i < 4; i++) begin
         g = N'(1) << (i % 2);
         #1;
         chk("grant_rr", 64'(req_ready), 64'(g));
         sbq.push_back('{i % 2, exp_mem[(i % 2 == 0) ? 1 : 2], cyc + 2});
         step();
         chk("rr_addr", 64'(mem_addr), 64'((i % 2 == 0) ? 1 : 2));
      end
      req_valid = '0;
      drain(3);

      do_req(1, 1'b1, 4'd3, 32'h0000_1234);
      do_req(0, 1'b0, 4'd3, 32'h0);
      drain(3);

      do_req(0, 1'b0, 4'd5, 32'h0);
      init_start = 1'b1;
      req_valid  = '1;
      #1;
      chk("init_start_no_grant", 64'(req_ready), 64'(0));
      step();
      init_start = 1'b0;
      req_valid  = '0;
      sweep();
      do_req(0, 1'b0, 4'd5, 32'h0);
      drain(3);

      init_start = 1'b1;
      step();
      init_start = 1'b0;
      drain(7);
      chk("mid_sweep_addr", 64'(mem_addr), 64'(6));
      rst = 1'b1;
      #1;
      chk("arst_cen", 64'(mem_cen), 64'(1));
      chk("arst_wen", 64'(mem_wen), 64'(1));
      chk("arst_addr", 64'(mem_addr), 64'(0));
      chk("arst_d", 64'(mem_d), 64'(0));
      chk("arst_busy", 64'(init_busy), 64'(1));
      step();
      rst = 1'b0;
      sweep();

      do_req(1, 1'b0, 4'd7, 32'h0);
      rst = 1'b1;
      sbq.delete();
      #1;
      chk("arst_rsp", 64'(rsp_valid), 64'(0));
      drain(3);
      rst = 1'b0;
      sweep();
      do_req(1, 1'b0, 4'd7, 32'h0);
      drain(3);

      chk("sb_empty", 64'(sbq.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spram_arbiter.md
# spram_arbiter

Round-robin arbiter and init sequencer for one single-port SRAM (active-low `cen`/`wen`, one-cycle registered read). Shares the macro between `NUM_REQ` requesters through valid/ready request ports and returns read data through per-requester response strobes. After every reset, or on `init_start`, it sweeps the whole array with `INIT_VALUE` before granting anyone. It sits between the hashing/compute engines and each SRAM bank.

## Interface
- `NUM_REQ`, 2: number of requesters (≥2).
- `MEM_WIDTH`, 32: data width.
- `MEM_DEPTH`, 4096: words; `AW = clog2(MEM_DEPTH)`, using ceil-log2.
- `INIT_VALUE`, 0: word written by the init sweep.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester.
- `req_ready`  out  NUM_REQ  one-hot grant; transfer occurs when `req_valid[i]` and `req_ready[i]` are both high at a rising edge.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*AW  packed address; requester i occupies `[i*AW +: AW]`.
- `req_wdata`  in  NUM_REQ*MEM_WIDTH  packed write data.
- `rsp_valid`  out  NUM_REQ  one-cycle read-data strobe for the requester.
- `rsp_rdata`  out  MEM_WIDTH  read data (= `mem_q`).
- `init_start`  in  1  request a re-initialisation sweep.
- `init_busy`  out  1  high while in INIT.
- `mem_cen`, `mem_wen`  out  1  SRAM chip/write enable, active-low, registered.
- `mem_addr`  out  AW  registered.
- `mem_d`  out  MEM_WIDTH  registered.
- `mem_q`  in  MEM_WIDTH  SRAM read data.

## Operation
- States: INIT, SERVE. `rst` forces INIT with `cnt=0`, `rr_ptr=0`.
- **INIT:** each edge registers `mem_cen=0`, `mem_wen=0`, `mem_addr=cnt`, `mem_d=INIT_VALUE`, then `cnt++`. The edge that registers `addr=MEM_DEPTH-1` also moves the state to SERVE and clears `cnt`. `req_ready` is all 0 and `init_start` is ignored.
- **SERVE, grant:** `req_ready` is combinational. It grants the first `req_valid` bit found scanning from `rr_ptr` upward with wrap. At most one bit is high. It is all 0 when `init_start=1` or no request is valid.
- **SERVE, accept from i:** the next edge registers `mem_cen=0`, `mem_wen=~req_we[i]`, and requester i's address and data, then sets `rr_ptr=(i+1) mod NUM_REQ`.
- **SERVE, no accept:** `mem_cen=1`, `mem_wen=1`; `mem_addr`/`mem_d` hold; `rr_ptr` holds.
- **Read tracking:** a 2-stage pipeline of {valid, requester id}. `rsp_valid[id]` pulses exactly one cycle per accepted read. Writes produce no response.
- **`init_start=1` in SERVE:** no grant that cycle; the state moves to INIT at that edge. An in-flight read still produces its `rsp_valid` on schedule.
- **Back-to-back:** one accept per cycle sustained; all requesters active gives strict rotation, no starvation.
- A read and a write to the same address in consecutive cycles are handled in order; the read returns the old or new data per SRAM order of issue.

## Timing
- Reset values: `req_ready=0`, `rsp_valid=0`, `init_busy=1`, `mem_cen=1`, `mem_wen=1`, `mem_addr=0`, `mem_d=0`.
- `init_busy` is high for exactly MEM_DEPTH cycles after `rst` falls (or after the `init_start` edge). The first grant is possible in the cycle the last init write is on the pins.
- **Read latency:** accept at edge E0; pins are valid after E0; the SRAM captures at E1; `rsp_valid` and `mem_q` are valid between E1 and E2. Response arrives 2 cycles after accept.
- **Write:** the SRAM captures at the edge after accept.
- `rst` asserted mid-sweep or mid-read: outputs go to reset values immediately; the pending response is dropped; the sweep restarts from address 0.

## Test plan
- **Reset/init** (MEM_DEPTH=16): release `rst` → `init_busy` high 16 cycles; addresses 0..15 written with `INIT_VALUE`; `req_ready=0` throughout.
- **Single read:** req0 reads addr 5 (preloaded `0xA5`) → `mem_cen=0`/`mem_wen=1` next cycle; `rsp_valid=2'b01`, `rsp_rdata=0xA5` 2 cycles after accept.
- **Contention:** both valid every cycle, reads to addr 1/2 → grants alternate 0,1,0,1; responses alternate with matching data.
- **Write then read:** req1 writes `0x1234` to addr 3, then req0 reads addr 3 → `0x1234` returned, and no `rsp_valid` for the write.
- **`init_start` with a read in flight:** read accepted at E0, `init_start` at E1 → `rsp_valid` still pulses; no grant during 16 busy cycles; a subsequent read returns `INIT_VALUE`.
- **Reset mid-sweep at cnt=7:** sweep restarts at addr 0; `init_busy` lasts the full 16 cycles.
